// File: rtl/sysmgr_rst_ctrl_if.sv
// -----------------------------------------------------------------------------
// sysmgr_rst_ctrl_if
// Signal bundle between the reset/PLL supervisor and its surroundings.
//   btn_n         : async pushbutton, low = pressed             (into supervisor)
//   sw_rst_req    : async software reset request, rising edge    (into supervisor)
//   pll_lock      : async PLL lock indicator                     (into supervisor)
//   pll_rst       : active-high reset to the PLL generator       (from supervisor)
//   sys_ok        : PLL qualified locked, system running         (from supervisor)
//   fault         : lock never achieved within the retry budget  (from supervisor)
//   retry_cnt     : failed attempts in the current sequence      (from supervisor)
//   lock_lost_cnt : lock losses while running, saturating        (from supervisor)
//   state         : FSM state encoding for debug                 (from supervisor)
// master = the environment driving the inputs, slave = the supervisor itself.
// -----------------------------------------------------------------------------
interface sysmgr_rst_ctrl_if;
    logic       btn_n;
    logic       sw_rst_req;
    logic       pll_lock;
    logic       pll_rst;
    logic       sys_ok;
    logic       fault;
    logic [7:0] retry_cnt;
    logic [7:0] lock_lost_cnt;
    logic [2:0] state;

    modport master (
        output btn_n, sw_rst_req, pll_lock,
        input  pll_rst, sys_ok, fault, retry_cnt, lock_lost_cnt, state
    );

    modport slave (
        input  btn_n, sw_rst_req, pll_lock,
        output pll_rst, sys_ok, fault, retry_cnt, lock_lost_cnt, state
    );
endinterface

// File: rtl/sysmgr_rst_ctrl.sv
// -----------------------------------------------------------------------------
// sysmgr_rst_ctrl
// Reset/PLL supervisor on the free-running board reference clock. Holds the
// PLL generator in reset after power-on, pulses its reset per lock attempt,
// qualifies lock with a consecutive-cycle filter, retries on lock timeout,
// latches a fault after the retry budget, and recovers from lock loss.
// Ports:
//   clk   : free-running board reference clock
//   rst_n : asynchronous active-low reset
//   bus   : sysmgr_rst_ctrl_if.slave (async inputs, registered status outputs)
// -----------------------------------------------------------------------------
module sysmgr_rst_ctrl #(
    parameter int unsigned POR_CYCLES      = 4096,
    parameter int unsigned PLL_RST_CYCLES  = 16,
    parameter int unsigned LOCK_FILTER     = 8,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    sysmgr_rst_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_POR       = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int unsigned MAX_AB  = (POR_CYCLES > PLL_RST_CYCLES) ? POR_CYCLES : PLL_RST_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int          CW      = $clog2(CNT_MAX + 1);
    localparam int          LW      = $clog2(LOCK_FILTER + 1);
    localparam int          DW      = $clog2(DEBOUNCE_CYCLES + 1);

    logic          btn_meta_r, btn_sync_r;
    logic          sw_meta_r, sw_sync_r, sw_prev_r;
    logic          lock_meta_r, lock_sync_r;
    logic          btn_pressed_r, btn_prev_r;
    logic [DW-1:0] deb_cnt_r;
    logic [CW-1:0] cnt_r;
    logic [LW-1:0] lock_cnt_r;
    state_t        state_r, state_next_s;
    logic [7:0]    retry_cnt_r, retry_next_s;
    logic [7:0]    lock_lost_cnt_r, lost_next_s;
    logic          pll_rst_r, sys_ok_r, fault_r;
    logic          sw_evt_s, btn_rise_s, btn_mismatch_s;

    // Two-flop synchronizers for the three asynchronous inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_r  <= 1'b1;
            btn_sync_r  <= 1'b1;
            sw_meta_r   <= 1'b0;
            sw_sync_r   <= 1'b0;
            sw_prev_r   <= 1'b0;
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            btn_meta_r  <= bus.btn_n;
            btn_sync_r  <= btn_meta_r;
            sw_meta_r   <= bus.sw_rst_req;
            sw_sync_r   <= sw_meta_r;
            sw_prev_r   <= sw_sync_r;
            lock_meta_r <= bus.pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    assign sw_evt_s       = sw_sync_r & ~sw_prev_r;
    // btn_n is active low, so equality with btn_pressed means disagreement.
    assign btn_mismatch_s = (btn_sync_r == btn_pressed_r);
    assign btn_rise_s     = btn_pressed_r & ~btn_prev_r;

    // Debouncer: flip the pressed state after DEBOUNCE_CYCLES disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_pressed_r <= 1'b0;
            btn_prev_r    <= 1'b0;
            deb_cnt_r     <= '0;
        end else begin
            btn_prev_r <= btn_pressed_r;
            if (btn_mismatch_s) begin
                if (deb_cnt_r >= DW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_pressed_r <= ~btn_pressed_r;
                    deb_cnt_r     <= '0;
                end else begin
                    deb_cnt_r <= deb_cnt_r + DW'(1);
                end
            end else begin
                deb_cnt_r <= '0;
            end
        end
    end

    // Next-state, retry and lock-loss bookkeeping.
    always_comb begin
        state_next_s = state_r;
        retry_next_s = retry_cnt_r;
        lost_next_s  = lock_lost_cnt_r;
        case (state_r)
            ST_POR: begin
                if (cnt_r >= CW'(POR_CYCLES - 1)) state_next_s = ST_PLL_RST;
                else                              state_next_s = ST_POR;
            end
            ST_PLL_RST: begin
                // A held button keeps the PLL in reset past the minimum pulse.
                if ((cnt_r >= CW'(PLL_RST_CYCLES - 1)) && !btn_pressed_r) state_next_s = ST_WAIT_LOCK;
                else                                                    state_next_s = ST_PLL_RST;
            end
            ST_WAIT_LOCK: begin
                // Lock qualification has priority over the timeout.
                if (lock_cnt_r == LW'(LOCK_FILTER)) begin
                    state_next_s = ST_RUN;
                    retry_next_s = 8'd0;
                end else if (btn_rise_s || sw_evt_s) begin
                    state_next_s = ST_PLL_RST;
                end else if (cnt_r >= CW'(LOCK_TIMEOUT - 1)) begin
                    if (retry_cnt_r == 8'(MAX_RETRY)) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_PLL_RST;
                        retry_next_s = retry_cnt_r + 8'd1;
                    end
                end else begin
                    state_next_s = ST_WAIT_LOCK;
                end
            end
            ST_RUN: begin
                if (!lock_sync_r) begin
                    state_next_s = ST_PLL_RST;
                    lost_next_s  = (lock_lost_cnt_r == 8'hFF) ? lock_lost_cnt_r : lock_lost_cnt_r + 8'd1;
                end else if (btn_rise_s || sw_evt_s) begin
                    state_next_s = ST_PLL_RST;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (btn_rise_s || sw_evt_s) begin
                    state_next_s = ST_PLL_RST;
                    retry_next_s = 8'd0;
                end else begin
                    state_next_s = ST_FAULT;
                end
            end
            default: begin
                state_next_s = ST_POR;
            end
        endcase
    end

    // Shared dwell counter: clears on each state change, stops at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_next_s != state_r) begin
            cnt_r <= '0;
        end else if (cnt_r != CW'(CNT_MAX)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Lock filter: consecutive synced-lock-high samples while staying in WAIT_LOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_r <= '0;
        end else if ((state_r == ST_WAIT_LOCK) && (state_next_s == ST_WAIT_LOCK)) begin
            if (!lock_sync_r)                          lock_cnt_r <= '0;
            else if (lock_cnt_r != LW'(LOCK_FILTER))   lock_cnt_r <= lock_cnt_r + LW'(1);
            else                                       lock_cnt_r <= lock_cnt_r;
        end else begin
            lock_cnt_r <= '0;
        end
    end

    // State and outputs registered from the next state so they change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_POR;
            pll_rst_r       <= 1'b1;
            sys_ok_r        <= 1'b0;
            fault_r         <= 1'b0;
            retry_cnt_r     <= 8'd0;
            lock_lost_cnt_r <= 8'd0;
        end else begin
            state_r         <= state_next_s;
            pll_rst_r       <= (state_next_s == ST_POR) || (state_next_s == ST_PLL_RST) ||
                               (state_next_s == ST_FAULT);
            sys_ok_r        <= (state_next_s == ST_RUN);
            fault_r         <= (state_next_s == ST_FAULT);
            retry_cnt_r     <= retry_next_s;
            lock_lost_cnt_r <= lost_next_s;
        end
    end

    assign bus.pll_rst       = pll_rst_r;
    assign bus.sys_ok        = sys_ok_r;
    assign bus.fault         = fault_r;
    assign bus.retry_cnt     = retry_cnt_r;
    assign bus.lock_lost_cnt = lock_lost_cnt_r;
    assign bus.state         = state_r;
endmodule

// File: tb/tb_sysmgr_rst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysmgr_rst_ctrl
// Self-checking bench for sysmgr_rst_ctrl. A timestamp-based reference model
// (input delay lines, line-stability run lengths, cycle-of-entry bookkeeping)
// predicts every output each cycle; directed sequences add targeted checks.
// -----------------------------------------------------------------------------
module tb_sysmgr_rst_ctrl;
    localparam int P  = 10;
    localparam int R  = 4;
    localparam int F  = 3;
    localparam int T  = 20;
    localparam int D  = 5;
    localparam int MR = 2;

    localparam int S_POR = 0, S_RST = 1, S_WAIT = 2, S_RUN = 3, S_FAULT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sysmgr_rst_ctrl_if bus();

    sysmgr_rst_ctrl #(
        .POR_CYCLES(P), .PLL_RST_CYCLES(R), .LOCK_FILTER(F),
        .LOCK_TIMEOUT(T), .DEBOUNCE_CYCLES(D), .MAX_RETRY(MR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_phase = S_POR, m_retry = 0, m_lost = 0;
    int cyc = 0, entered = 0, last_low = 0;
    int bt_run = 0;
    bit bt_lvl = 1'b1;
    bit m_pressed = 1'b0, m_pressed_prev = 1'b0;
    bit lk_q [0:1] = '{1'b0, 1'b0};
    bit bt_q [0:1] = '{1'b1, 1'b1};
    bit sw_q [0:2] = '{1'b0, 1'b0, 1'b0};

    initial begin : ref_model
        int  nxt, dwell;
        bit  lk, bt, sw_evt, btn_rise;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = S_POR; m_retry = 0; m_lost = 0;
                cyc = 0; entered = 0; last_low = 0;
                bt_run = 0; bt_lvl = 1'b1;
                m_pressed = 1'b0; m_pressed_prev = 1'b0;
                lk_q = '{1'b0, 1'b0};
                bt_q = '{1'b1, 1'b1};
                sw_q = '{1'b0, 1'b0, 1'b0};
            end else begin
                lk       = lk_q[1];
                bt       = bt_q[1];
                sw_evt   = sw_q[1] && !sw_q[2];
                btn_rise = m_pressed && !m_pressed_prev;
                cyc++;
                dwell = cyc - entered;
                nxt   = m_phase;
                case (m_phase)
                    S_POR:  if (dwell >= P) nxt = S_RST;
                    S_RST:  if (dwell >= R && !m_pressed) nxt = S_WAIT;
                    S_WAIT: begin
                        if (cyc - 1 - last_low >= F) begin
                            nxt = S_RUN; m_retry = 0;
                        end else if (btn_rise || sw_evt) begin
                            nxt = S_RST;
                        end else if (dwell >= T) begin
                            if (m_retry == MR) nxt = S_FAULT;
                            else begin m_retry++; nxt = S_RST; end
                        end
                    end
                    S_RUN: begin
                        if (!lk) begin
                            nxt = S_RST;
                            if (m_lost < 255) m_lost++;
                        end else if (btn_rise || sw_evt) begin
                            nxt = S_RST;
                        end
                    end
                    S_FAULT: if (btn_rise || sw_evt) begin m_retry = 0; nxt = S_RST; end
                    default: nxt = S_POR;
                endcase
                if (nxt != m_phase) begin
                    entered = cyc; last_low = cyc;
                end else if (m_phase == S_WAIT && !lk) begin
                    last_low = cyc;
                end
                m_phase = nxt;
                // button: how long has the synced line been at its current level
                if (bt == bt_lvl) bt_run++;
                else begin bt_lvl = bt; bt_run = 1; end
                m_pressed_prev = m_pressed;
                if (((bt == 1'b0) != m_pressed) && bt_run >= D) m_pressed = !m_pressed;
                lk_q[1] = lk_q[0]; lk_q[0] = bus.pll_lock;
                bt_q[1] = bt_q[0]; bt_q[0] = bus.btn_n;
                sw_q[2] = sw_q[1]; sw_q[1] = sw_q[0]; sw_q[0] = bus.sw_rst_req;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin : scoreboard
        forever begin
            @(negedge clk);
            chk("pll_rst", 32'(bus.pll_rst), 32'((m_phase == S_POR) || (m_phase == S_RST) || (m_phase == S_FAULT)));
            chk("sys_ok", 32'(bus.sys_ok), 32'(m_phase == S_RUN));
            chk("fault", 32'(bus.fault), 32'(m_phase == S_FAULT));
            chk("state", 32'(bus.state), 32'(m_phase));
            chk("retry_cnt", 32'(bus.retry_cnt), 32'(m_retry));
            chk("lock_lost_cnt", 32'(bus.lock_lost_cnt), 32'(m_lost));
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (bus.state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", 32'(bus.state), 32'(s));
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n, btn_hold, sw_hold;
        bus.btn_n = 1'b1; bus.sw_rst_req = 1'b0; bus.pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pll_rst", 32'(bus.pll_rst), 32'd1);
        chk("rst_sys_ok", 32'(bus.sys_ok), 32'd0);
        chk("rst_state", 32'(bus.state), 32'd0);

        // power-on: lock tied high
        rst_n = 1'b1;
        n = 0;
        while (bus.pll_rst === 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("por_len", 32'(n), 32'(P + R));
        n = 0;
        while (bus.sys_ok !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("wait_to_run", 32'(n), 32'(F + 1));
        chk("run_retry", 32'(bus.retry_cnt), 32'd0);

        // lock never comes: retries then fault
        bus.pll_lock = 1'b0;
        wait_state(3'd4, 200);
        chk("fault_flag", 32'(bus.fault), 32'd1);
        chk("fault_pll_rst", 32'(bus.pll_rst), 32'd1);
        chk("fault_retry", 32'(bus.retry_cnt), 32'(MR));
        repeat (10) @(negedge clk);
        chk("fault_held", 32'(bus.fault), 32'd1);

        // button clears the fault and holds reset while pressed
        bus.btn_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("fault_clr", 32'(bus.fault), 32'd0);
        chk("fault_clr_retry", 32'(bus.retry_cnt), 32'd0);
        chk("btn_hold_state", 32'(bus.state), 32'd1);
        bus.pll_lock = 1'b1;
        bus.btn_n = 1'b1;
        wait_state(3'd3, 60);

        // lock-rise latency from an unlocked WAIT_LOCK
        bus.pll_lock = 1'b0;
        wait_state(3'd2, 30);
        bus.pll_lock = 1'b1;
        n = 0;
        while (bus.sys_ok !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("lock_to_ok", 32'(n), 32'(2 + F + 1));

        // lock-fall latency and repeated one-cycle drops
        @(negedge clk); bus.pll_lock = 1'b0;
        @(negedge clk); bus.pll_lock = 1'b1;
        n = 1;
        while (bus.sys_ok === 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("loss_to_rst", 32'(n), 32'd3);
        wait_state(3'd3, 40);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); bus.pll_lock = 1'b0;
            @(negedge clk); bus.pll_lock = 1'b1;
            wait_state(3'd1, 10);
            wait_state(3'd3, 40);
        end
        chk("lost_sat", 32'(bus.lock_lost_cnt), 32'd255);

        // button glitch shorter than debounce: ignored
        bus.btn_n = 1'b0; repeat (4) @(negedge clk); bus.btn_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_ignored", 32'(bus.state), 32'd3);
        // 6-cycle press: accepted
        bus.btn_n = 1'b0; repeat (6) @(negedge clk); bus.btn_n = 1'b1;
        wait_state(3'd1, 20);
        wait_state(3'd3, 60);
        // long press holds reset until release plus debounce
        bus.btn_n = 1'b0; repeat (20) @(negedge clk);
        chk("press_held", 32'(bus.state), 32'd1);
        chk("press_pll_rst", 32'(bus.pll_rst), 32'd1);
        bus.btn_n = 1'b1;
        wait_state(3'd2, 30);
        wait_state(3'd3, 30);

        // lock pattern 1,1,0 then steady 1s in WAIT_LOCK
        bus.pll_lock = 1'b0;
        wait_state(3'd2, 30);
        bus.pll_lock = 1'b1; @(negedge clk);
        @(negedge clk);
        bus.pll_lock = 1'b0; @(negedge clk);
        bus.pll_lock = 1'b1;
        n = 0;
        while (bus.sys_ok !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("toggle_to_ok", 32'(n), 32'(2 + F + 1));

        // lock qualifies on the timeout cycle of a retry attempt
        bus.pll_lock = 1'b0;
        wait_state(3'd2, 30);
        wait_state(3'd1, 40);
        chk("timeout_retry", 32'(bus.retry_cnt), 32'd1);
        wait_state(3'd2, 20);
        repeat (T - F - 6) @(negedge clk);
        bus.pll_lock = 1'b1;
        repeat (6) @(negedge clk);
        chk("tie_state", 32'(bus.state), 32'd3);
        chk("tie_retry", 32'(bus.retry_cnt), 32'd0);

        // randomized traffic
        btn_hold = 0; sw_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(39, 0) == 0) bus.pll_lock = ~bus.pll_lock;
            if (btn_hold > 0) begin
                btn_hold--;
                if (btn_hold == 0) bus.btn_n = 1'b1;
            end else if ($urandom_range(199, 0) == 0) begin
                bus.btn_n = 1'b0; btn_hold = $urandom_range(12, 1);
            end
            if (sw_hold > 0) begin
                sw_hold--;
                if (sw_hold == 0) bus.sw_rst_req = 1'b0;
            end else if ($urandom_range(149, 0) == 0) begin
                bus.sw_rst_req = 1'b1; sw_hold = $urandom_range(3, 1);
            end
        end
        bus.btn_n = 1'b1; bus.sw_rst_req = 1'b0; bus.pll_lock = 1'b1;
        repeat (12) @(negedge clk);
        bus.sw_rst_req = 1'b1; repeat (2) @(negedge clk); bus.sw_rst_req = 1'b0;
        wait_state(3'd3, 200);

        // asynchronous reset mid-RUN
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pll_rst", 32'(bus.pll_rst), 32'd1);
        chk("arst_sys_ok", 32'(bus.sys_ok), 32'd0);
        chk("arst_fault", 32'(bus.fault), 32'd0);
        chk("arst_retry", 32'(bus.retry_cnt), 32'd0);
        chk("arst_lost", 32'(bus.lock_lost_cnt), 32'd0);
        chk("arst_state", 32'(bus.state), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_state(3'd3, 60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
